alu_result_scoreboard: RTL and testbench
========================================

Name: alu_result_scoreboard

Overview:
- Synthesizable response-side checker for the ALU: the receiving end of the ALU stimulus flow.
- A stimulus source pushes expected result/flags entries into an in-order FIFO. ALU results arriving later are popped against them and compared.
- Keeps pass/fail counts, captures the first mismatch, and reports a final verdict after an end-of-test drain.
- Sits beside the ALU in bench and bring-up builds.

Parameters:
- WORD_WIDTH, 32: width of the ALU result word.
- FLAGS_WIDTH, 4: width of the ALU flags vector.
- DEPTH, 8: number of expected-FIFO entries; must be a power of two, at least 2.
- CNT_WIDTH, 16: width of the pass/fail/index counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  FIFO can accept an entry (= !full)
- exp_out  in  WORD_WIDTH  expected result
- exp_flags  in  FLAGS_WIDTH  expected flags
- exp_flags_mask  in  FLAGS_WIDTH  1 = compare this flag bit
- act_valid  in  1  ALU result offered
- act_ready  out  1  result can be accepted (= !empty and state != DONE)
- act_out  in  WORD_WIDTH  ALU result
- act_flags  in  FLAGS_WIDTH  ALU flags
- end_test  in  1  single-cycle pulse: no more stimulus follows
- cmp_valid  out  1  one-cycle pulse: a comparison completed
- cmp_pass  out  1  result of that comparison; valid with cmp_valid
- pass_count  out  CNT_WIDTH  matching comparisons
- fail_count  out  CNT_WIDTH  mismatching comparisons
- first_fail_valid  out  1  a mismatch has been captured
- first_fail_index  out  CNT_WIDTH  ordinal (from 0) of the first mismatch
- first_fail_act  out  WORD_WIDTH  act_out of the first mismatch
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- done  out  1  DONE state reached
- all_pass  out  1  done and fail_count == 0

Behaviour:
- Reset: all outputs 0; exp_ready = 1; FIFO empty; state = RUN.
- Reset mid-operation discards FIFO contents and clears all counters and captures.

Handshakes:
- Expected push when exp_valid && exp_ready.
- Actual pop when act_valid && act_ready.
- Both ready signals are derived from registered state only. There is no bypass:
  - When full, a same-cycle pop does not allow a push.
  - When empty, a same-cycle push does not allow a pop.
- Simultaneous push and pop when neither full nor empty: fill_level unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full and empty come from an extra pointer bit or the occupancy counter.

Compare:
- On pop, match = (act_out == exp_out) && ((act_flags ^ exp_flags) & exp_flags_mask) == 0.
- Result is registered: cmp_valid/cmp_pass assert exactly 1 cycle after the pop cycle.
- Counters update in that same cycle.
- pass_count and fail_count saturate at all-ones.
- The compare ordinal (pass_count + fail_count before the update) saturates likewise.

First fail:
- On the first mismatch, capture first_fail_index = ordinal and first_fail_act, and set first_fail_valid.
- Later mismatches do not overwrite the capture.

FSM:
- RUN: if end_test, go to DRAIN.
- DRAIN:
  - exp pushes are still accepted.
  - When FIFO empty and no comparison is in flight (the registered compare stage is idle), go to DONE.
- DONE:
  - done = 1; all_pass = (fail_count == 0).
  - exp_ready = 0 and act_ready = 0.
  - Held until rst.
- end_test in DRAIN or DONE is ignored.
- end_test with an empty FIFO reaches DONE 2 cycles later: one cycle in DRAIN, then DONE.

Test Plan:
1. Push exp (0x00000031, flags 0001, mask 1111); one cycle later send act (0x00000031, 0001) → cmp_valid pulse 1 cycle after the pop, cmp_pass=1, pass_count=1, fail_count=0.
2. Push 3 entries, then send acts with the 2nd act_out=0xDEADBEEF (mismatch) → pass_count=2, fail_count=1, first_fail_index=1, first_fail_act=0xDEADBEEF; a later 4th mismatch leaves the capture unchanged.
3. Push 8 entries with act_valid=0 → exp_ready=0, fill_level=8. Hold exp_valid with a pop in the same cycle → no push that cycle, fill_level=7, exp_ready=1 next cycle. Continue for ≥2*DEPTH entries to confirm pointer wrap-around order.
4. Mask test: exp flags 0000 with mask 1110; act flags 0001 → pass. The same with mask 1111 → fail.
5. Push 2 entries, pulse end_test, send 2 acts → done=1 only after the 2nd comparison registers; all_pass=1; act_ready=0 and exp_ready=0 in DONE.
6. Assert rst with 4 entries queued and fail_count=1 → all outputs 0 next cycle, fill_level=0, exp_ready=1, state RUN.

Source files
------------

// File: rtl/alu_result_scoreboard.sv
// ALU response checker: expected entries queue in order; ALU results pop and compare against them.
// Latency: compare result and counters register 1 cycle after the pop; DONE follows the drain.
// Backpressure: exp_ready = !full, act_ready = !empty; both read registered state only, no bypass.
module alu_result_scoreboard #(
   parameter int WORD_WIDTH  = 32,
   parameter int FLAGS_WIDTH = 4,
   parameter int DEPTH       = 8,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     exp_valid,
   output logic                     exp_ready,
   input  logic [WORD_WIDTH-1:0]    exp_out,
   input  logic [FLAGS_WIDTH-1:0]   exp_flags,
   input  logic [FLAGS_WIDTH-1:0]   exp_flags_mask,
   input  logic                     act_valid,
   output logic                     act_ready,
   input  logic [WORD_WIDTH-1:0]    act_out,
   input  logic [FLAGS_WIDTH-1:0]   act_flags,
   input  logic                     end_test,
   output logic                     cmp_valid,
   output logic                     cmp_pass,
   output logic [CNT_WIDTH-1:0]     pass_count,
   output logic [CNT_WIDTH-1:0]     fail_count,
   output logic                     first_fail_valid,
   output logic [CNT_WIDTH-1:0]     first_fail_index,
   output logic [WORD_WIDTH-1:0]    first_fail_act,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     done,
   output logic                     all_pass
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [WORD_WIDTH-1:0]  mem_out   [DEPTH];
   logic [FLAGS_WIDTH-1:0] mem_flags [DEPTH];
   logic [FLAGS_WIDTH-1:0] mem_mask  [DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            count;
   logic                   full, empty, push, pop, match;
   logic [CNT_WIDTH:0]     ord_sum;
   logic [CNT_WIDTH-1:0]   ordinal;

   assign full       = (count == (AW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign exp_ready  = !full && (state != DONE);
   assign act_ready  = !empty && (state != DONE);
   assign push       = exp_valid && exp_ready;
   assign pop        = act_valid && act_ready;
   assign fill_level = count;
   assign done       = (state == DONE);
   assign all_pass   = done && (fail_count == '0);

   // Masked flag bits are don't-care; the result word always compares in full.
   assign match = (act_out == mem_out[rd_ptr]) &&
                  (((act_flags ^ mem_flags[rd_ptr]) & mem_mask[rd_ptr]) == '0);

   // Ordinal of the comparison being retired, clamped at all-ones like the counters.
   assign ord_sum = {1'b0, pass_count} + {1'b0, fail_count};
   assign ordinal = ord_sum[CNT_WIDTH] ? '1 : ord_sum[CNT_WIDTH-1:0];

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_out[wr_ptr]   <= exp_out;
         mem_flags[wr_ptr] <= exp_flags;
         mem_mask[wr_ptr]  <= exp_flags_mask;
      end
   end

   // Pointers wrap naturally at DEPTH; the occupancy counter resolves full vs empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered compare stage with saturating pass/fail counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_valid  <= 1'b0;
         cmp_pass   <= 1'b0;
         pass_count <= '0;
         fail_count <= '0;
      end else begin
         cmp_valid <= pop;
         if (pop) begin
            cmp_pass <= match;
            if (match) begin
               if (pass_count != '1) pass_count <= pass_count + 1'b1;
            end else begin
               if (fail_count != '1) fail_count <= fail_count + 1'b1;
            end
         end
      end
   end

   // Keep only the first mismatch so later failures cannot hide the root cause.
   always_ff @(posedge clk) begin
      if (rst) begin
         first_fail_valid <= 1'b0;
         first_fail_index <= '0;
         first_fail_act   <= '0;
      end else if (pop && !match && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_index <= ordinal;
         first_fail_act   <= act_out;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next state: drain finishes once the queue is empty and the compare stage has retired.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (end_test) state_nxt = DRAIN;
         DRAIN:   if (empty && !cmp_valid) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_alu_result_scoreboard.sv
// Bench for alu_result_scoreboard: directed steps plus random traffic against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every cycle goes through one task that advances the model and checks every output.
module tb_alu_result_scoreboard;

   localparam int W    = 32;
   localparam int FW   = 4;
   localparam int DEPTH = 8;
   localparam int CW   = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          exp_valid, exp_ready;
   logic [W-1:0]  exp_out;
   logic [FW-1:0] exp_flags, exp_flags_mask;
   logic          act_valid, act_ready;
   logic [W-1:0]  act_out;
   logic [FW-1:0] act_flags;
   logic          end_test;
   logic          cmp_valid, cmp_pass;
   logic [CW-1:0] pass_count, fail_count;
   logic          first_fail_valid;
   logic [CW-1:0] first_fail_index;
   logic [W-1:0]  first_fail_act;
   logic [$clog2(DEPTH):0] fill_level;
   logic          done, all_pass;

   alu_result_scoreboard #(.WORD_WIDTH(W), .FLAGS_WIDTH(FW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_out(exp_out),
      .exp_flags(exp_flags), .exp_flags_mask(exp_flags_mask),
      .act_valid(act_valid), .act_ready(act_ready), .act_out(act_out), .act_flags(act_flags),
      .end_test(end_test), .cmp_valid(cmp_valid), .cmp_pass(cmp_pass),
      .pass_count(pass_count), .fail_count(fail_count),
      .first_fail_valid(first_fail_valid), .first_fail_index(first_fail_index),
      .first_fail_act(first_fail_act), .fill_level(fill_level),
      .done(done), .all_pass(all_pass)
   );

   always #5 clk = ~clk;

   // Reference model: plain queue of pending expectations plus scalar tallies.
   typedef struct packed {
      logic [W-1:0]  o;
      logic [FW-1:0] f;
      logic [FW-1:0] m;
   } ent_t;

   ent_t     mq[$];
   int       m_pass, m_fail, m_ffi, m_phase;   // phase: 0 running, 1 draining, 2 finished
   bit       m_ffv, m_cmp, m_cmpp;
   logic [W-1:0] m_ffa;
   int       tests = 0;
   int       fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_pass = 0; m_fail = 0; m_ffi = 0; m_phase = 0;
      m_ffv = 0; m_cmp = 0; m_cmpp = 0; m_ffa = '0;
   endtask

   task automatic check_outputs();
      chk("cmp_valid", cmp_valid, m_cmp);
      if (m_cmp) chk("cmp_pass", cmp_pass, m_cmpp);
      chk("pass_count", pass_count, m_pass);
      chk("fail_count", fail_count, m_fail);
      chk("first_fail_valid", first_fail_valid, m_ffv);
      chk("first_fail_index", first_fail_index, m_ffi);
      chk("first_fail_act", first_fail_act, m_ffa);
      chk("fill_level", fill_level, mq.size());
      chk("done", done, m_phase == 2);
      chk("all_pass", all_pass, (m_phase == 2) && (m_fail == 0));
   endtask

   // One clock: check readiness, predict handshakes, advance the model, check outputs.
   task automatic cycle();
      bit   pu, po, mt;
      int   sz, ph_next, ord;
      ent_t h;
      sz = mq.size();
      chk("exp_ready", exp_ready, (sz < DEPTH) && (m_phase != 2));
      chk("act_ready", act_ready, (sz > 0) && (m_phase != 2));
      pu = exp_valid && (sz < DEPTH) && (m_phase != 2);
      po = act_valid && (sz > 0) && (m_phase != 2);
      ph_next = m_phase;
      if (m_phase == 0 && end_test) ph_next = 1;
      else if (m_phase == 1 && sz == 0 && !m_cmp) ph_next = 2;
      @(posedge clk);
      #1;
      if (rst) begin
         model_clear();
      end else begin
         m_cmp = po;
         if (po) begin
            h = mq.pop_front();
            mt = (act_out == h.o) && (((act_flags ^ h.f) & h.m) == 0);
            m_cmpp = mt;
            ord = (m_pass + m_fail > CMAX) ? CMAX : m_pass + m_fail;
            if (mt) m_pass = (m_pass + 1 > CMAX) ? CMAX : m_pass + 1;
            else begin
               if (!m_ffv) begin
                  m_ffv = 1; m_ffi = ord; m_ffa = act_out;
               end
               m_fail = (m_fail + 1 > CMAX) ? CMAX : m_fail + 1;
            end
         end
         if (pu) mq.push_back('{o: exp_out, f: exp_flags, m: exp_flags_mask});
         m_phase = ph_next;
      end
      check_outputs();
   endtask

   task automatic push_exp(input logic [W-1:0] o, input logic [FW-1:0] f, input logic [FW-1:0] m);
      exp_valid = 1; exp_out = o; exp_flags = f; exp_flags_mask = m;
      cycle();
      exp_valid = 0;
   endtask

   task automatic send_act(input logic [W-1:0] o, input logic [FW-1:0] f);
      act_valid = 1; act_out = o; act_flags = f;
      cycle();
      act_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=no_finish required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      ent_t e[4];
      int   guard;
      rst = 1; exp_valid = 0; exp_out = '0; exp_flags = '0; exp_flags_mask = '0;
      act_valid = 0; act_out = '0; act_flags = '0; end_test = 0;
      repeat (3) @(posedge clk);
      #1;
      model_clear();
      chk("rst_exp_ready", exp_ready, 1);
      chk("rst_act_ready", act_ready, 0);
      check_outputs();
      rst = 0;

      // Basic match: compare pulse one cycle after the pop.
      push_exp(32'h31, 4'b0001, 4'b1111);
      send_act(32'h31, 4'b0001);
      chk("t1_cmp_valid", cmp_valid, 1);
      chk("t1_cmp_pass", cmp_pass, 1);
      chk("t1_pass", pass_count, 1);
      chk("t1_fail", fail_count, 0);
      cycle();
      chk("t1_pulse_end", cmp_valid, 0);

      // Single mismatch among three, then a later mismatch must not move the capture.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         e[i].o = $urandom & 32'h7fff_ffff;
         e[i].f = FW'($urandom_range(0, 15));
         e[i].m = 4'hf;
      end
      for (int i = 0; i < 3; i++) push_exp(e[i].o, e[i].f, e[i].m);
      send_act(e[0].o, e[0].f);
      send_act(32'hDEAD_BEEF, e[1].f);
      chk("t2_cmp_pass_bad", cmp_pass, 0);
      send_act(e[2].o, e[2].f);
      cycle();
      chk("t2_pass", pass_count, 2);
      chk("t2_fail", fail_count, 1);
      chk("t2_ffi", first_fail_index, 1);
      chk("t2_ffa", first_fail_act, 32'hDEAD_BEEF);
      push_exp(e[3].o, e[3].f, e[3].m);
      send_act(~e[3].o, e[3].f);
      chk("t2_fail2", fail_count, 2);
      chk("t2_ffi_kept", first_fail_index, 1);
      chk("t2_ffa_kept", first_fail_act, 32'hDEAD_BEEF);

      // Fill to full, pop-while-full does not admit a push, then random traffic through wrap.
      for (int i = 0; i < DEPTH; i++) push_exp($urandom, FW'($urandom_range(0, 15)), 4'hf);
      chk("t3_full_ready", exp_ready, 0);
      chk("t3_full_level", fill_level, DEPTH);
      exp_valid = 1; exp_out = $urandom; exp_flags = 4'h3; exp_flags_mask = 4'hf;
      act_valid = 1; act_out = mq[0].o; act_flags = mq[0].f;
      cycle();
      act_valid = 0; exp_valid = 0;
      chk("t3_no_push_level", fill_level, DEPTH - 1);
      chk("t3_ready_again", exp_ready, 1);
      for (int i = 0; i < 48; i++) begin
         exp_valid = ($urandom_range(0, 3) != 0);
         exp_out = $urandom; exp_flags = FW'($urandom_range(0, 15));
         exp_flags_mask = FW'($urandom_range(0, 15));
         act_valid = ($urandom_range(0, 1) != 0);
         if (mq.size() > 0) begin
            act_out = mq[0].o; act_flags = mq[0].f;
            if ($urandom_range(0, 7) == 0) act_out = act_out ^ 32'h1;
            if ($urandom_range(0, 3) == 0) act_flags = FW'($urandom_range(0, 15));
         end else begin
            act_out = $urandom; act_flags = '0;
         end
         cycle();
      end
      exp_valid = 0;
      guard = 0;
      while (mq.size() > 0 && guard < 3 * DEPTH) begin
         act_valid = 1; act_out = mq[0].o; act_flags = mq[0].f;
         cycle();
         guard++;
      end
      act_valid = 0;
      cycle();
      chk("t3_drained", fill_level, 0);

      // Flag mask: masked-off bit differences are ignored.
      do_reset();
      push_exp(32'h0, 4'b0000, 4'b1110);
      send_act(32'h0, 4'b0001);
      chk("t4_masked_pass", cmp_pass, 1);
      push_exp(32'h0, 4'b0000, 4'b1111);
      send_act(32'h0, 4'b0001);
      chk("t4_unmasked_fail", cmp_pass, 0);

      // End-of-test drain with two pending entries.
      do_reset();
      push_exp(32'h11, 4'h1, 4'hf);
      push_exp(32'h22, 4'h2, 4'hf);
      end_test = 1;
      cycle();
      end_test = 0;
      send_act(32'h11, 4'h1);
      chk("t5_done_early1", done, 0);
      send_act(32'h22, 4'h2);
      chk("t5_done_at_cmp", done, 0);
      cycle();
      chk("t5_done_early2", done, 0);
      cycle();
      chk("t5_done", done, 1);
      chk("t5_all_pass", all_pass, 1);
      chk("t5_act_ready", act_ready, 0);
      chk("t5_exp_ready", exp_ready, 0);
      end_test = 1;
      cycle();
      end_test = 0;
      chk("t5_done_held", done, 1);

      // end_test with an empty queue: one cycle draining, then finished; pushes refused after.
      do_reset();
      end_test = 1;
      cycle();
      end_test = 0;
      chk("t5b_drain", done, 0);
      cycle();
      chk("t5b_done", done, 1);
      exp_valid = 1; exp_out = 32'h55;
      cycle();
      exp_valid = 0;
      chk("t5b_no_push", fill_level, 0);

      // Reset with queued entries and a recorded failure.
      do_reset();
      for (int i = 0; i < 5; i++) push_exp($urandom, 4'h0, 4'hf);
      send_act(~mq[0].o, 4'h0);
      chk("t6_pre_fail", fail_count, 1);
      chk("t6_pre_level", fill_level, 4);
      do_reset();
      chk("t6_cmp_valid", cmp_valid, 0);
      chk("t6_pass", pass_count, 0);
      chk("t6_fail", fail_count, 0);
      chk("t6_ffv", first_fail_valid, 0);
      chk("t6_ffi", first_fail_index, 0);
      chk("t6_ffa", first_fail_act, 0);
      chk("t6_level", fill_level, 0);
      chk("t6_exp_ready", exp_ready, 1);
      chk("t6_act_ready", act_ready, 0);
      chk("t6_done", done, 0);
      chk("t6_all_pass", all_pass, 0);
      push_exp(32'h77, 4'h5, 4'hf);
      send_act(32'h77, 4'h5);
      chk("t6_run_pass", pass_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
